// File: rtl/gray_pkg.sv
// Width limits and Gray/binary conversion helpers shared by the Gray-code counter.
// Both helpers operate on the maximum width; narrower values are zero-extended.
package gray_pkg;

   localparam int GRAY_WIDTH_MIN = 2;
   localparam int GRAY_WIDTH_MAX = 16;

   function automatic logic [GRAY_WIDTH_MAX-1:0] bin2gray(input logic [GRAY_WIDTH_MAX-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Zero-extended upper bits leave the prefix-XOR unchanged, so any WIDTH up to the max converts correctly.
   function automatic logic [GRAY_WIDTH_MAX-1:0] gray2bin(input logic [GRAY_WIDTH_MAX-1:0] g);
      logic [GRAY_WIDTH_MAX-1:0] b;
      b[GRAY_WIDTH_MAX-1] = g[GRAY_WIDTH_MAX-1];
      for (int i = GRAY_WIDTH_MAX-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_bin2gray.sv
// Purely combinational WIDTH-bit binary-to-Gray converter.
// Each Gray bit is the XOR of a binary bit and its upper neighbour.
module gray_bin2gray
   import gray_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] bin_val,
   output logic [WIDTH-1:0] gray_val
);

   assign gray_val[WIDTH-1] = bin_val[WIDTH-1];

   for (genvar gi = 0; gi < WIDTH-1; gi++) begin : g_bit
      assign gray_val[gi] = bin_val[gi] ^ bin_val[gi+1];
   end

endmodule

// File: rtl/gray_counter.sv
// Gray-code counter with registered Gray/binary outputs, load, enable and wrap pulse.
// Define GRAY_CNT_DOWN_EN to honour dir (down-counting); otherwise the block counts up only.
module gray_counter
   import gray_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             dir,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
   localparam logic [WIDTH-1:0] CNT_MAX = '1;

   if (WIDTH < GRAY_WIDTH_MIN || WIDTH > GRAY_WIDTH_MAX) begin : g_width_check
      $error("gray_counter: WIDTH %0d outside %0d..%0d", WIDTH, GRAY_WIDTH_MIN, GRAY_WIDTH_MAX);
   end

   logic [WIDTH-1:0] cnt_reg;
   logic [WIDTH-1:0] cnt_next;
   logic [WIDTH-1:0] gray_reg;
   logic [WIDTH-1:0] gray_next;
   logic             wrap_reg;
   logic             wrap_next;

`ifdef GRAY_CNT_DOWN_EN
   logic step_down;
   assign step_down = ~dir;
`else
   logic dir_unused;
   assign dir_unused = dir;
`endif

   // Priority: load over enabled step over hold; only an enabled step may wrap.
   always_comb begin
      cnt_next  = cnt_reg;
      wrap_next = 1'b0;
      if (load) begin
         cnt_next = load_val;
      end else if (en) begin
`ifdef GRAY_CNT_DOWN_EN
         if (step_down) begin
            cnt_next  = cnt_reg - CNT_ONE;
            wrap_next = (cnt_reg == '0);
         end else begin
            cnt_next  = cnt_reg + CNT_ONE;
            wrap_next = (cnt_reg == CNT_MAX);
         end
`else
         cnt_next  = cnt_reg + CNT_ONE;
         wrap_next = (cnt_reg == CNT_MAX);
`endif
      end
   end

   gray_bin2gray #(
      .WIDTH (WIDTH)
   ) u_bin2gray (
      .bin_val  (cnt_next),
      .gray_val (gray_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg  <= '0;
         gray_reg <= '0;
         wrap_reg <= 1'b0;
      end else begin
         cnt_reg  <= cnt_next;
         gray_reg <= gray_next;
         wrap_reg <= wrap_next;
      end
   end

   assign gray = gray_reg;
   assign bin  = cnt_reg;
   assign wrap = wrap_reg;

endmodule
